// File: rtl/rv32i_dmem_bridge.sv
// rv32i_dmem_bridge: one-outstanding-request bridge from the memory-access stage to a fixed-latency word SRAM
module rv32i_dmem_bridge #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          MEM_LATENCY = 1,
   parameter int          AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_stb,
   input  logic          i_wr_en,
   input  logic [3:0]    i_wr_mask,
   input  logic [31:0]   i_addr,
   input  logic [31:0]   i_wdata,
   output logic          o_ack,
   output logic [31:0]   o_rdata,
   output logic          o_err,
   output logic          o_busy,
   output logic          o_overrun,
   output logic          o_mem_en,
   output logic [3:0]    o_mem_we,
   output logic [AW-1:0] o_mem_addr,
   output logic [31:0]   o_mem_wdata,
   input  logic [31:0]   i_mem_rdata
);
   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
   localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;
   state_t        r_state, w_next;
   logic [2:0]    r_cnt;
   logic [AW-1:0] r_addr;
   logic          r_we, r_err, r_overrun;
   logic [3:0]    r_mask;
   logic [31:0]   r_wdata, r_rdata;
   logic [31:0]   w_off;
   logic          w_in_range, w_accept;
   // unsigned offset: addresses below BASE wrap high and fail the range check
   assign w_off      = i_addr - BASE_ADDR;
   assign w_in_range = {1'b0, w_off} < LIMIT;
   assign w_accept   = (r_state == IDLE) && i_stb;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= 3'd0;
         r_addr    <= '0;
         r_we      <= 1'b0;
         r_mask    <= 4'h0;
         r_wdata   <= 32'h0;
         r_rdata   <= 32'h0;
         r_err     <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_state <= w_next;
         if (i_stb && r_state != IDLE) r_overrun <= 1'b1;
         if (w_accept) begin
            r_addr  <= w_off[AW+1:2];
            r_we    <= i_wr_en;
            r_mask  <= i_wr_mask;
            r_wdata <= i_wdata;
            r_err   <= !w_in_range;
            if (!w_in_range) r_rdata <= 32'h0;
         end
         if (r_state == ACCESS) begin
            r_cnt <= 3'(MEM_LATENCY - 1);
            if (r_we) r_rdata <= 32'h0;
         end
         if (r_state == WAIT) begin
            r_cnt <= r_cnt - 3'd1;
            if (r_cnt == 3'd0) r_rdata <= i_mem_rdata;
         end
      end
   end
   always_comb begin
      w_next   = r_state;
      o_mem_en = 1'b0;
      o_mem_we = 4'h0;
      unique case (r_state)
         IDLE:    w_next = i_stb ? (w_in_range ? ACCESS : RESP) : IDLE;
         ACCESS: begin
            w_next   = r_we ? RESP : WAIT;
            o_mem_en = !r_we || (|r_mask);
            o_mem_we = r_we ? r_mask : 4'h0;
         end
         WAIT:    w_next = (r_cnt == 3'd0) ? RESP : WAIT;
         default: w_next = IDLE;
      endcase
   end
   assign o_ack       = r_state == RESP;
   assign o_err       = o_ack && r_err;
   assign o_busy      = r_state != IDLE;
   assign o_overrun   = r_overrun;
   assign o_rdata     = r_rdata;
   assign o_mem_addr  = r_addr;
   assign o_mem_wdata = r_wdata;
endmodule

// File: tb/tb_rv32i_dmem_bridge.sv
// tb_rv32i_dmem_bridge: randomized requests checked against a word-array reference model
module tb_rv32i_dmem_bridge;
   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam int DEPTH = 16;
   localparam int LAT   = 3;
   localparam int AW    = 4;
   logic          clk = 1'b0, rst_n = 1'b0, stb = 1'b0, wr_en = 1'b0;
   logic [3:0]    mask = 4'h0;
   logic [31:0]   addr = 32'h0, wdata = 32'h0;
   logic          ack, err, busy, overrun, mem_en;
   logic [31:0]   rdata, mem_wdata, mem_rdata;
   logic [3:0]    mem_we;
   logic [AW-1:0] mem_addr;
   int            checks = 0, failures = 0;
   logic [31:0]   ref_mem [DEPTH];
   logic [31:0]   sram [DEPTH];
   logic [31:0]   pd [LAT];
   logic          pv [LAT];
   logic          exp_ovr = 1'b0;
   rv32i_dmem_bridge #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .MEM_LATENCY(LAT)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_stb(stb), .i_wr_en(wr_en), .i_wr_mask(mask),
      .i_addr(addr), .i_wdata(wdata), .o_ack(ack), .o_rdata(rdata), .o_err(err),
      .o_busy(busy), .o_overrun(overrun), .o_mem_en(mem_en), .o_mem_we(mem_we),
      .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
   );
   always #5 clk = ~clk;
   // SRAM model: read data appears LAT cycles after the enable cycle, garbage otherwise
   always @(posedge clk) begin
      logic [31:0] nw;
      for (int k = LAT - 1; k > 0; k--) begin
         pd[k] <= pd[k-1];
         pv[k] <= pv[k-1];
      end
      pd[0] <= sram[mem_addr];
      pv[0] <= mem_en && mem_we == 4'h0;
      nw = sram[mem_addr];
      for (int b = 0; b < 4; b++) if (mem_we[b]) nw[8*b +: 8] = mem_wdata[8*b +: 8];
      if (mem_en) sram[mem_addr] <= nw;
   end
   assign mem_rdata = pv[LAT-1] ? pd[LAT-1] : 32'h5A5A_A5A5;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic req(input logic wr, input logic [3:0] m, input logic [31:0] a, input logic [31:0] wd, input logic ovr);
      logic [31:0]   off, exp_rd;
      logic [AW-1:0] idx;
      logic          oor;
      int            lat;
      off    = a - BASE;
      oor    = off >= 32'(4 * DEPTH);
      idx    = off[AW+1:2];
      lat    = oor ? 1 : (wr ? 2 : 2 + LAT);
      exp_rd = (oor || wr) ? 32'h0 : ref_mem[idx];
      stb = 1'b1; wr_en = wr; mask = m; addr = a; wdata = wd;
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         if (c == 1) begin
            stb = ovr;
            if (ovr) exp_ovr = 1'b1;
            addr = $urandom; wr_en = ~wr; mask = ~m; wdata = $urandom;
         end
         check("ack", 32'(ack), 32'(c == lat));
         check("busy", 32'(busy), 32'd1);
         check("mem_en", 32'(mem_en), 32'(c == 1 && !oor && (!wr || m != 4'h0)));
         check("mem_we", 32'(mem_we), (c == 1 && !oor && wr) ? 32'(m) : 32'h0);
         if (c == 1 && !oor) check("mem_addr", 32'(mem_addr), 32'(idx));
         if (c == 1 && !oor && wr) check("mem_wdata", mem_wdata, wd);
      end
      check("err", 32'(err), 32'(oor));
      check("rdata", rdata, exp_rd);
      if (wr && !oor) for (int b = 0; b < 4; b++) if (m[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
      @(negedge clk);
      stb = 1'b0;
      check("ack_idle", 32'(ack), 32'h0);
      check("busy_idle", 32'(busy), 32'h0);
      check("rdata_hold", rdata, exp_rd);
      check("overrun", 32'(overrun), 32'(exp_ovr));
   endtask
   initial begin
      @(negedge clk);
      check("rst_ack", 32'(ack), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_ovr", 32'(overrun), 32'h0);
      check("rst_en", 32'(mem_en), 32'h0);
      check("rst_we", 32'(mem_we), 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_maddr", 32'(mem_addr), 32'h0);
      check("rst_mwdata", mem_wdata, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < DEPTH; i++) req(1'b1, 4'hF, BASE + 32'(4 * i), $urandom, 1'b0);
      req(1'b1, 4'hF, BASE + 32'h10, 32'hDEAD_BEEF, 1'b0);
      req(1'b0, 4'h0, BASE + 32'h10, 32'h0, 1'b0);
      req(1'b1, 4'hF, BASE + 32'h10, 32'hCAFE_F00D, 1'b0);
      req(1'b0, 4'h0, BASE + 32'h12, 32'h0, 1'b0);
      req(1'b1, 4'b0100, BASE + 32'h6, 32'h00AB_0000, 1'b0);
      req(1'b0, 4'h0, BASE + 32'h4, 32'h0, 1'b0);
      req(1'b1, 4'h0, BASE + 32'h8, 32'hFFFF_FFFF, 1'b0);
      req(1'b0, 4'h0, BASE + 32'h8, 32'h0, 1'b0);
      req(1'b0, 4'h0, BASE + 32'(4 * DEPTH), 32'h0, 1'b0);
      req(1'b1, 4'hF, BASE - 32'd4, 32'h1234_5678, 1'b0);
      req(1'b0, 4'h0, BASE + 32'h3C, 32'h0, 1'b1);
      req(1'b1, 4'b0011, BASE + 32'h3C, 32'h0000_BEEF, 1'b0);
      req(1'b0, 4'h0, BASE + 32'h3F, 32'h0, 1'b0);
      // abort a load while it waits on the SRAM
      stb = 1'b1; wr_en = 1'b0; addr = BASE + 32'h12;
      @(negedge clk);
      stb = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_ack", 32'(ack), 32'h0);
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_ovr", 32'(overrun), 32'h0);
      check("abort_rdata", rdata, 32'h0);
      check("abort_en", 32'(mem_en), 32'h0);
      exp_ovr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("post_rst_ack", 32'(ack), 32'h0);
      end
      req(1'b0, 4'h0, BASE + 32'h12, 32'h0, 1'b0);
      for (int i = 0; i < 80; i++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 7) == 0) ? $urandom : BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
         req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom, $urandom_range(0, 7) == 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
